// File: rtl/ifetch_fq.sv
// ifetch_fq: instruction fetch unit with an N-way set-associative I-cache,
// a 2-bit-counter branch history table and a fetch queue that decouples
// cache lookup from decoder back-pressure. Misses are refilled one line at
// a time through a two-state refill FSM talking to the memory controller.
module ifetch_fq #(
    parameter int LINE_WORDS  = 16,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int BHT_ENTRIES = 256,
    parameter int FQ_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    stall,
    output logic                    out_valid,
    output logic [31:0]             out_inst,
    output logic [31:0]             out_pc,
    output logic                    out_pred_jump,
    output logic                    mc_en,
    output logic [31:0]             mc_addr,
    input  logic                    mc_done,
    input  logic [32*LINE_WORDS-1:0] mc_data,
    input  logic                    redirect_en,
    input  logic [31:0]             redirect_pc,
    input  logic                    br_upd,
    input  logic                    br_taken,
    input  logic [31:0]             br_pc
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_LO = OFF_W + IDX_W + 2;
    localparam int TAG_W  = 32 - TAG_LO;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BHT_W  = $clog2(BHT_ENTRIES);
    localparam int PTR_W  = $clog2(FQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Saturating 2-bit counter step: up on taken (cap 3), down on not taken (floor 0).
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

    // ---------------- state ----------------
    logic [31:0]             r_pc;
    logic [SETS-1:0]         r_valid [WAYS];
    logic [TAG_W-1:0]        r_tag   [WAYS][SETS];
    logic [32*LINE_WORDS-1:0] r_data [WAYS][SETS];
    logic [SETS-1:0]         r_lru;
    logic [1:0]              r_bht   [BHT_ENTRIES];

    logic [31:0]             r_fq_inst [FQ_DEPTH];
    logic [31:0]             r_fq_pc   [FQ_DEPTH];
    logic [FQ_DEPTH-1:0]     r_fq_pj;
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_mc_addr;
    logic [WAY_W-1:0]        r_victim;

    // ---------------- combinational ----------------
    logic [OFF_W-1:0]        w_off;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [WAY_W-1:0]        w_victim;
    logic [32*LINE_WORDS-1:0] w_line;
    logic [31:0]             w_words [LINE_WORDS];
    logic [31:0]             w_inst;
    logic [6:0]              w_opcode;
    logic signed [31:0]      w_jimm;
    logic signed [31:0]      w_bimm;
    logic [BHT_W-1:0]        w_bht_idx;
    logic [BHT_W-1:0]        w_upd_idx;
    logic [1:0]              w_bht_ctr;
    logic [31:0]             w_pred_pc;
    logic                    w_pred_jump;
    logic                    w_full;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_start;
    logic                    w_install;
    logic [IDX_W-1:0]        w_ins_idx;
    logic [TAG_W-1:0]        w_ins_tag;
    logic                    w_unused;

    assign w_off     = r_pc[OFF_W+1:2];
    assign w_idx     = r_pc[TAG_LO-1:OFF_W+2];
    assign w_tag     = r_pc[31:TAG_LO];
    assign w_ins_idx = r_mc_addr[TAG_LO-1:OFF_W+2];
    assign w_ins_tag = r_mc_addr[31:TAG_LO];
    assign w_bht_idx = r_pc[BHT_W+1:2];
    assign w_upd_idx = br_pc[BHT_W+1:2];
    assign w_bht_ctr = r_bht[w_bht_idx];

    // Only the index field of the resolved-branch PC addresses the BHT.
    assign w_unused = ^{br_pc[31:BHT_W+2], br_pc[1:0]};

    // Tag compare across all ways of the set selected by the current PC.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        w_victim = WAY_W'(r_lru[w_idx]);
        if (WAYS == 1) w_victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
        end
    end

    assign w_line = r_data[w_hit_way][w_idx];

    // Split the hit line into words so the offset can select one directly.
    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            w_words[k] = w_line[32*k +: 32];
        end
    end

    assign w_inst   = w_words[w_off];
    assign w_opcode = w_inst[6:0];
    assign w_jimm   = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                       w_inst[30:21], 1'b0};
    assign w_bimm   = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                       w_inst[11:8], 1'b0};

    // Static JAL prediction plus BHT-driven conditional branch prediction.
    always_comb begin
        w_pred_pc   = r_pc + 32'd4;
        w_pred_jump = 1'b0;
        if (w_opcode == OP_JAL) begin
            w_pred_pc   = r_pc + $unsigned(w_jimm);
            w_pred_jump = 1'b1;
        end else if ((w_opcode == OP_BRANCH) && w_bht_ctr[1]) begin
            w_pred_pc   = r_pc + $unsigned(w_bimm);
            w_pred_jump = 1'b1;
        end
    end

    // Full is taken from the registered count so a full queue never accepts
    // an entry, even when the head is being popped in the same cycle.
    assign w_full = (r_count == CNT_W'(FQ_DEPTH));
    assign w_enq  = rdy && w_hit && !w_full && !redirect_en;
    assign w_deq  = rdy && out_valid && !stall && !redirect_en;

    // Refill FSM next-state: start a refill on a miss from IDLE, finish on mc_done.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_install   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rdy && !w_hit && !redirect_en) begin
                    w_state_nxt = S_WAIT;
                    w_start     = 1'b1;
                end
            end
            S_WAIT: begin
                if (rdy && mc_done) begin
                    w_state_nxt = S_IDLE;
                    w_install   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Refill FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the line address and victim way when a refill is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mc_addr <= '0;
            r_victim  <= '0;
        end else if (w_start) begin
            r_mc_addr <= {r_pc[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
            r_victim  <= w_victim;
        end
    end

    // Valid and LRU bookkeeping; a refill install overrides a same-set hit update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
            r_lru <= '0;
        end else if (rdy) begin
            if (w_enq && (WAYS > 1)) begin
                r_lru[w_idx] <= ~w_hit_way[0];
            end
            if (w_install) begin
                r_valid[r_victim][w_ins_idx] <= 1'b1;
                if (WAYS > 1) r_lru[w_ins_idx] <= ~r_victim[0];
            end
        end
    end

    // Tag and line storage, written only when a refill completes.
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[r_victim][w_ins_idx]  <= w_ins_tag;
            r_data[r_victim][w_ins_idx] <= mc_data;
        end
    end

    // Branch history: counters start weakly not-taken and train on ROB updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (rdy && br_upd) begin
            r_bht[w_upd_idx] <= bht_next(r_bht[w_upd_idx], br_taken);
        end
    end

    // Fetch PC: redirect wins, otherwise advance to the predicted PC on enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (rdy) begin
            if (redirect_en) begin
                r_pc <= redirect_pc;
            end else if (w_enq) begin
                r_pc <= w_pred_pc;
            end
        end
    end

    // Fetch queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (redirect_en) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + PTR_W'(1);
                if (w_deq) r_head <= r_head + PTR_W'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Fetch queue payload storage.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fq_inst[r_tail] <= w_inst;
            r_fq_pc[r_tail]   <= r_pc;
            r_fq_pj[r_tail]   <= w_pred_jump;
        end
    end

    // Head is shown straight from queue storage; zeros while the queue is empty.
    assign out_valid     = (r_count != '0);
    assign out_inst      = out_valid ? r_fq_inst[r_head] : 32'd0;
    assign out_pc        = out_valid ? r_fq_pc[r_head]   : 32'd0;
    assign out_pred_jump = out_valid ? r_fq_pj[r_head]   : 1'b0;

    assign mc_en   = (r_state == S_WAIT);
    assign mc_addr = r_mc_addr;

endmodule

// File: tb/tb_ifetch_fq.sv
// Directed testbench for ifetch_fq: cold start, JAL/BHT prediction,
// back-pressure, redirect during a refill, 2-way conflict eviction,
// rdy freeze and reset while a refill is outstanding.
module tb_ifetch_fq;

    localparam int LW = 16;

    logic           clk;
    logic           rst;
    logic           rdy;
    logic           stall;
    logic           out_valid;
    logic [31:0]    out_inst;
    logic [31:0]    out_pc;
    logic           out_pred_jump;
    logic           mc_en;
    logic [31:0]    mc_addr;
    logic           mc_done;
    logic [32*LW-1:0] mc_data;
    logic           redirect_en;
    logic [31:0]    redirect_pc;
    logic           br_upd;
    logic           br_taken;
    logic [31:0]    br_pc;

    int checks = 0;
    int errors = 0;

    ifetch_fq #(
        .LINE_WORDS (LW),
        .SETS       (16),
        .WAYS       (2),
        .BHT_ENTRIES(256),
        .FQ_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_pred_jump(out_pred_jump),
        .mc_en        (mc_en),
        .mc_addr      (mc_addr),
        .mc_done      (mc_done),
        .mc_data      (mc_data),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .br_upd       (br_upd),
        .br_taken     (br_taken),
        .br_pc        (br_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: JAL +0x40 at 0x10, BEQ +8 at 0x54, NOPs elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0400006F;
            32'h54:  return 32'h00000463;
            default: return 32'h00000013;
        endcase
    endfunction

    function automatic logic [32*LW-1:0] line_of(input logic [31:0] base);
        logic [32*LW-1:0] l;
        for (int w = 0; w < LW; w++) begin
            l[32*w +: 32] = mem_word(base + 32'(4*w));
        end
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [31:0] base);
        mc_data = line_of(base);
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_en = 1'b1;
        redirect_pc = pc;
        step();
        redirect_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; stall = 1'b0; mc_done = 1'b0; mc_data = '0;
        redirect_en = 1'b0; redirect_pc = '0; br_upd = 1'b0; br_taken = 1'b0; br_pc = '0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst got %h want 0", out_inst); end
        checks++; if (out_pred_jump !== 1'b0) begin errors++; $display("FAIL rst_pred got %b want 0", out_pred_jump); end
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL rst_mc_en got %b want 0", mc_en); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL rst_mc_addr got %h want 0", mc_addr); end
        rst = 1'b0;
    endtask

    task automatic test_cold_start();
        step();
        checks++; if (mc_en !== 1'b1) begin errors++; $display("FAIL cold_mc_en got %b want 1", mc_en); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL cold_mc_addr got %h want 0", mc_addr); end
        step();
        checks++; if (mc_en !== 1'b1) begin errors++; $display("FAIL cold_mc_en_held got %b want 1", mc_en); end
        pulse_done(32'h0);
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL cold_mc_en_drop got %b want 0", mc_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cold_valid_early got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cold_valid got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL cold_pc got %h want 0", out_pc); end
        checks++; if (out_inst !== 32'h00000013) begin errors++; $display("FAIL cold_inst got %h want 00000013", out_inst); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*i)) begin
                errors++; $display("FAIL cold_stream[%0d] got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'(4*i));
            end
        end
    endtask

    task automatic test_jal();
        step();
        checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL jal_pc got %h want 10", out_pc); end
        checks++; if (out_inst !== 32'h0400006F) begin errors++; $display("FAIL jal_inst got %h want 0400006f", out_inst); end
        checks++; if (out_pred_jump !== 1'b1) begin errors++; $display("FAIL jal_pred got %b want 1", out_pred_jump); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_drain got %b want 0", out_valid); end
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h40) begin
            errors++; $display("FAIL jal_refill got en=%b addr=%h want en=1 addr=40", mc_en, mc_addr); end
        pulse_done(32'h40);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h50 || out_pred_jump !== 1'b0) begin
            errors++; $display("FAIL jal_target got v=%b pc=%h pj=%b want v=1 pc=50 pj=0", out_valid, out_pc, out_pred_jump); end
        step();
        checks++; if (out_pc !== 32'h54 || out_inst !== 32'h00000463) begin
            errors++; $display("FAIL beq_fetch got pc=%h inst=%h want pc=54 inst=00000463", out_pc, out_inst); end
        checks++; if (out_pred_jump !== 1'b0) begin errors++; $display("FAIL beq_weak_nt got %b want 0", out_pred_jump); end
        step();
        checks++; if (out_pc !== 32'h58) begin errors++; $display("FAIL beq_fallthru got %h want 58", out_pc); end
    endtask

    task automatic test_back_pressure();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h58) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b pc=%h want v=1 pc=58", i, out_valid, out_pc);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h5c + 32'(4*i)) begin
                errors++; $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'h5c + 32'(4*i));
            end
        end
    endtask

    task automatic test_bht();
        br_upd = 1'b1; br_taken = 1'b1; br_pc = 32'h54;
        step();
        step();
        br_upd = 1'b0; br_taken = 1'b0;
        do_redirect(32'h54);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bht_flush got %b want 0", out_valid); end
        step();
        checks++; if (out_pc !== 32'h54 || out_pred_jump !== 1'b1) begin
            errors++; $display("FAIL bht_taken got pc=%h pj=%b want pc=54 pj=1", out_pc, out_pred_jump); end
        step();
        checks++; if (out_pc !== 32'h5c) begin errors++; $display("FAIL bht_target got %h want 5c", out_pc); end
    endtask

    task automatic test_redirect_miss();
        stall = 1'b1;
        do_redirect(32'h7c);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_flush1 got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h7c) begin
            errors++; $display("FAIL rm_head got v=%b pc=%h want v=1 pc=7c", out_valid, out_pc); end
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h80) begin
            errors++; $display("FAIL rm_miss got en=%b addr=%h want en=1 addr=80", mc_en, mc_addr); end
        step();
        do_redirect(32'h400);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_flush2 got %b want 0", out_valid); end
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h80) begin
            errors++; $display("FAIL rm_keep got en=%b addr=%h want en=1 addr=80", mc_en, mc_addr); end
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h80) begin
            errors++; $display("FAIL rm_nonew got en=%b addr=%h want en=1 addr=80", mc_en, mc_addr); end
        pulse_done(32'h80);
        checks++; if (mc_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_idle got en=%b v=%b want en=0 v=0", mc_en, out_valid); end
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h400) begin
            errors++; $display("FAIL rm_second got en=%b addr=%h want en=1 addr=400", mc_en, mc_addr); end
        pulse_done(32'h400);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_early got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            errors++; $display("FAIL rm_deliver got v=%b pc=%h want v=1 pc=400", out_valid, out_pc); end
        stall = 1'b0;
        do_redirect(32'h80);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || mc_en !== 1'b0) begin
            errors++; $display("FAIL rm_installed got v=%b pc=%h en=%b want v=1 pc=80 en=0", out_valid, out_pc, mc_en); end
    endtask

    task automatic test_conflict();
        do_redirect(32'h800);
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h800) begin
            errors++; $display("FAIL cf_miss800 got en=%b addr=%h want en=1 addr=800", mc_en, mc_addr); end
        pulse_done(32'h800);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h800) begin
            errors++; $display("FAIL cf_hit800 got v=%b pc=%h want v=1 pc=800", out_valid, out_pc); end
        do_redirect(32'h400);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || mc_en !== 1'b0) begin
            errors++; $display("FAIL cf_hit400 got v=%b pc=%h en=%b want v=1 pc=400 en=0", out_valid, out_pc, mc_en); end
        do_redirect(32'h0);
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL cf_evicted got en=%b addr=%h v=%b want en=1 addr=0 v=0", mc_en, mc_addr, out_valid); end
    endtask

    task automatic test_rdy_and_reset();
        stall = 1'b1;
        do_redirect(32'h408);
        for (int i = 0; i < 5; i++) step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h408) begin
            errors++; $display("FAIL rdy_fill got v=%b pc=%h want v=1 pc=408", out_valid, out_pc); end
        rdy = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h408 || mc_en !== 1'b1 || mc_addr !== 32'h0) begin
                errors++; $display("FAIL rdy_freeze[%0d] got v=%b pc=%h en=%b addr=%h want v=1 pc=408 en=1 addr=0",
                                   i, out_valid, out_pc, mc_en, mc_addr);
            end
        end
        rdy = 1'b1;
        step();
        checks++; if (out_pc !== 32'h40c || mc_en !== 1'b1) begin
            errors++; $display("FAIL rdy_resume got pc=%h en=%b want pc=40c en=1", out_pc, mc_en); end
        rst = 1'b1;
        step();
        checks++; if (mc_en !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || mc_addr !== 32'h0) begin
            errors++; $display("FAIL midrst got en=%b v=%b pc=%h addr=%h want all 0", mc_en, out_valid, out_pc, mc_addr); end
        rst = 1'b0;
        do_redirect(32'h400);
        step();
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h400 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_inval got en=%b addr=%h v=%b want en=1 addr=400 v=0", mc_en, mc_addr, out_valid); end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_jal();
        test_back_pressure();
        test_bht();
        test_redirect_miss();
        test_conflict();
        test_rdy_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
